// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with XNOR feedback, reversible stepping, seed load,
// lockup recovery from the all-ones state and a wrap pulse on return to start.
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             fb,
  output logic             wrap,
  output logic             lockup
);

  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] start_r;
  logic             wrap_r;
  logic [WIDTH-1:0] next_s;
  logic             wrap_next_s;
  logic             fb_s;
  logic             rev_x_s;
  logic             lockup_s;

  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    parity_f = ^v;
  endfunction

  // The reverse bit undoes the forward XNOR: out[0] is the feedback that shifted in,
  // so the bit that shifted out is recovered from it and the remaining tapped bits.
  assign fb_s     = ~parity_f(out_r & TAPS);
  assign rev_x_s  = ~out_r[0] ^ parity_f({1'b0, out_r[WIDTH-1:1] & TAPS[WIDTH-2:0]});
  assign lockup_s = &out_r;

  // Next-state selection: load, lockup recovery, forward/reverse step or hold.
  always_comb begin
    next_s      = out_r;
    wrap_next_s = 1'b0;
    if (load) begin
      next_s = seed_in;
    end else if (en) begin
      if (lockup_s) begin
        next_s = SEED;
      end else begin
        if (dir) begin
          next_s = {out_r[WIDTH-2:0], fb_s};
        end else begin
          next_s = {rev_x_s, out_r[WIDTH-1:1]};
        end
        wrap_next_s = (next_s == start_r);
      end
    end else begin
      next_s = out_r;
    end
  end

  // State, start-value and wrap registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r   <= SEED;
      start_r <= SEED;
      wrap_r  <= 1'b0;
    end else begin
      out_r  <= next_s;
      wrap_r <= wrap_next_s;
      if (load) begin
        start_r <= seed_in;
      end else begin
        start_r <= start_r;
      end
    end
  end

  assign out    = out_r;
  assign fb     = fb_s;
  assign wrap   = wrap_r;
  assign lockup = lockup_s;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a cycle-table reference model predicts each
// edge's result, a monitor compares it; directed checks cover the named scenarios.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       dir = 1'b1;
  logic [7:0] seed_in = 8'h00;
  logic [7:0] out;
  logic       fb;
  logic       wrap;
  logic       lockup;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] o;
    logic       w;
  } exp_t;
  exp_t q[$];

  // Reference: the maximal cycle as an ordered table; stepping is index arithmetic.
  logic [7:0] seq_tab[255];
  int         pos_of[256];
  logic [7:0] m_out;
  logic [7:0] m_start;

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .dir(dir), .out(out), .fb(fb), .wrap(wrap), .lockup(lockup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic fb_ref(input logic [7:0] v);
    return ($countones(v & 8'hB8) % 2) == 0;
  endfunction

  task automatic build_table();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 256; i++) pos_of[i] = -1;
    for (int i = 0; i < 255; i++) begin
      seq_tab[i] = s;
      pos_of[s] = i;
      s = {s[6:0], fb_ref(s)};
    end
  endtask

  task automatic model_reset();
    m_out   = 8'h00;
    m_start = 8'h00;
  endtask

  task automatic model_step(input logic e, input logic l, input logic d, input logic [7:0] s);
    exp_t x;
    int   p;
    x.w = 1'b0;
    if (l) begin
      m_out   = s;
      m_start = s;
    end else if (e) begin
      if (m_out == 8'hFF) begin
        m_out = 8'h00;
      end else begin
        p     = pos_of[m_out];
        m_out = d ? seq_tab[(p + 1) % 255] : seq_tab[(p + 254) % 255];
        x.w   = (m_out == m_start);
      end
    end
    x.o = m_out;
    q.push_back(x);
  endtask

  // Drive one edge's inputs at the falling edge, return 2 time units after the rising edge.
  task automatic drive(input logic e, input logic l, input logic d, input logic [7:0] s);
    @(negedge clk);
    en = e; load = l; dir = d; seed_in = s;
    model_step(e, l, d, s);
    @(posedge clk);
    #2;
  endtask

  // Monitor: DUT presents a new state every edge out of reset.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (reset && q.size() > 0) begin
      x = q.pop_front();
      chk("sb_out", out, x.o);
      chk("sb_wrap", wrap, x.w);
      chk("sb_lockup", lockup, x.o == 8'hFF);
      chk("sb_fb", fb, fb_ref(x.o));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp20[5];
    bit         seen[256];
    int         dups;
    exp20[0] = 8'h01; exp20[1] = 8'h03; exp20[2] = 8'h07; exp20[3] = 8'h0F; exp20[4] = 8'h1E;
    build_table();
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("reset_out", out, 8'h00);
    chk("reset_wrap", wrap, 1'b0);
    chk("reset_lockup", lockup, 1'b0);
    reset = 1'b1;

    // Five forward steps from SEED
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      chk("fwd5_out", out, exp20[i]);
    end

    // Asynchronous reset mid-cycle while out=1E
    #1 reset = 1'b0;
    #1;
    chk("async_rst_out", out, 8'h00);
    chk("async_rst_wrap", wrap, 1'b0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;

    // First step after reset proceeds from SEED, then reverse/forward round trip
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    chk("post_rst_out", out, 8'h01);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rev_out", out, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    chk("fwd_again_out", out, 8'h01);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    chk("hold_out", out, 8'h01);

    // Full period from reset
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    dups = 0;
    for (int k = 1; k <= 255; k++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      if (seen[out]) dups++;
      seen[out] = 1'b1;
      chk("period_wrap", wrap, k == 255);
    end
    chk("period_end_out", out, 8'h00);
    chk("period_distinct", dups, 0);

    // All-ones load and lockup recovery
    drive(1'b0, 1'b1, 1'b0, 8'hFF);
    chk("load_ff_out", out, 8'hFF);
    chk("load_ff_lockup", lockup, 1'b1);
    chk("load_ff_wrap", wrap, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk("recover_out", out, 8'h00);
    chk("recover_lockup", lockup, 1'b0);
    chk("recover_wrap", wrap, 1'b0);

    // Load has priority over en; wrap returns to the loaded value
    drive(1'b1, 1'b1, 1'b1, 8'h5A);
    chk("load5a_out", out, 8'h5A);
    chk("load5a_wrap", wrap, 1'b0);
    for (int k = 1; k <= 255; k++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      chk("wrap5a", wrap, k == 255);
    end
    chk("wrap5a_out", out, 8'h5A);

    // Load on the first edge after reset release
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'hC3);
    chk("first_edge_load", out, 8'hC3);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic       e, l, d;
      logic [7:0] s;
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 15) == 0);
      d = $urandom_range(0, 1);
      s = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      drive(e, l, d, s);
    end
    en = 1'b0; load = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8, giving the register width; legal range 3..64.
REQ-002 The module SHALL take parameter TAPS, default 8'hB8, a WIDTH-bit feedback tap mask; bit WIDTH-1 SHALL be 1.
REQ-003 The module SHALL take parameter SEED, default 0, a WIDTH-bit value used for the reset and lockup-recovery state.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  step enable.
- load  input  1  synchronous seed load; priority over en.
- seed_in  input  WIDTH  value loaded when load=1.
- dir  input  1  step direction: 1 forward, 0 reverse.
- out  output  WIDTH  registered LFSR state.
- fb  output  1  forward feedback bit of the current state (combinational).
- wrap  output  1  registered one-cycle pulse: sequence returned to start value.
- lockup  output  1  combinational flag: out is all-ones.

Function
REQ-005 Forward feedback SHALL be fb = XNOR-reduction of (out AND TAPS).
REQ-006 A forward step (en=1, load=0, dir=1, lockup=0) SHALL set out <= {out[WIDTH-2:0], fb}.
REQ-007 A reverse step (en=1, load=0, dir=0, lockup=0) SHALL set out <= {x, out[WIDTH-1:1]}, with x = NOT out[0] XOR parity(out[WIDTH-1:1] AND TAPS[WIDTH-2:0]).
REQ-008 A forward step applied after a reverse step SHALL restore the original state, and vice versa.
REQ-009 With load=1, out and the internal start register SHALL both take seed_in on the clock edge, regardless of en and dir.
REQ-010 With load=0 and en=0, out SHALL hold its value.
REQ-011 lockup SHALL equal 1 exactly when out equals all-ones; this includes an all-ones value written by load.
REQ-012 When en=1, load=0 and lockup=1, out SHALL take SEED in either direction, and wrap SHALL stay 0 on that edge.
REQ-013 wrap SHALL be 1 for the cycle after a normal step (REQ-006/007) whose next state equals the start register, and 0 otherwise.
REQ-014 Loads and lockup recoveries SHALL never assert wrap.
REQ-015 With the default parameters, the forward sequence from SEED SHALL have period 255, so wrap pulses once every 255 forward steps.
REQ-016 All outputs SHALL update only on the rising edge of clk, except fb and lockup (combinational from out) and the reset action (REQ-017).

Reset
REQ-017 While reset=0, the block SHALL immediately and independently of clk set out=SEED, start register=SEED and wrap=0.
REQ-018 Reset asserted mid-sequence SHALL discard the current state; the first step after reset deassertion SHALL proceed from SEED.
REQ-019 A load on the first edge after reset deassertion SHALL be honoured.

Verification (WIDTH=8, TAPS=8'hB8, SEED=0)
REQ-020 The bench SHALL release reset and hold en=1, dir=1 for 5 edges, and SHALL see out = 01, 03, 07, 0F, 1E.
REQ-021 The bench SHALL, from out=01, apply en=1, dir=0 for 1 edge, and SHALL see out=00; one further forward step SHALL give out=01.
REQ-022 The bench SHALL apply 255 consecutive forward steps from reset, and SHALL see wrap=1 only after step 255 with out=00, and all 255 states distinct.
REQ-023 The bench SHALL apply load=1 with seed_in=FF, and SHALL see out=FF and lockup=1; the next edge with en=1 SHALL give out=00, lockup=0, wrap=0.
REQ-024 The bench SHALL apply load=1, en=1, seed_in=5A on the same edge, and SHALL see out=5A with no step applied; wrap SHALL pulse after 255 further forward steps with out=5A.
REQ-025 The bench SHALL drive reset=0 between clock edges while out=1E, and SHALL see out=00 and wrap=0 before the next edge.
